if_axi_fetch: RTL
=================

// Module: if_axi_fetch
// PURPOSE
//   IF-stage instruction fetch master, directly downstream of the PC register. Takes the current PC,
//   issues one single-beat AXI4 read on the AR/R channels to instruction memory, buffers the
//   returned word and hands it to the IF/ID register. Asserts fetch_stall (drives PC-reg w_en low)
//   until an instruction is available. Drops the in-flight response on a branch/jump flush.
// PARAMETERS
//   PC_W      32  PC / ARADDR width
//   DATA_W    32  instruction / RDATA width
//   ID_W       4  ARID/RID width
//   FETCH_ID   0  ARID value used for every fetch; R beats with other RID are ignored
// PORTS
//   clk          in   1       clock, all state on rising edge
//   rst          in   1       asynchronous, active-low reset
//   pc           in   PC_W    PC from PC register
//   fetch_req    in   1       pipeline requests fetch at pc
//   flush        in   1       branch/jump redirect; current fetch is stale
//   instr_ack    in   1       IF/ID consumed instr this cycle
//   instr        out  DATA_W  fetched instruction
//   instr_valid  out  1       instr holds valid data
//   instr_err    out  1       RRESP != OKAY for this instr
//   fetch_stall  out  1       = ~instr_valid
//   araddr/arid/arlen/arsize/arburst  out  PC_W/ID_W/4/3/2  arlen=0, arsize=3'b010, arburst=2'b01
//   arvalid out 1 / arready in 1;  rdata in DATA_W, rid in ID_W, rresp in 2, rlast in 1, rvalid in 1, rready out 1
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, arvalid=0, rready=0, araddr=0, instr=32'h0000_0013 (NOP),
//     instr_valid=0, instr_err=0, discard=0; fetch_stall=1.
//   States: IDLE, ADDR, DATA, HOLD. All outputs registered except fetch_stall.
//   IDLE: fetch_req=1 -> araddr<={pc[PC_W-1:2],2'b00} (low bits forced to 0), arvalid<=1, ->ADDR.
//     flush in IDLE has no effect beyond using the pc presented that cycle.
//   ADDR: arvalid and araddr held stable until arready (AXI: never withdrawn). arvalid&arready
//     -> arvalid<=0, rready<=1, ->DATA. flush in ADDR -> discard<=1.
//   DATA: rready=1. Beat accepted when rvalid&rid==FETCH_ID&rlast; other RID ignored, rready stays 1.
//     Accepted & discard=0 -> instr<=rdata, instr_err<=(rresp!=2'b00), instr_valid<=1, rready<=0, ->HOLD.
//     rresp!=OKAY -> instr<=NOP instead of rdata.
//     Accepted & discard=1 -> data dropped, discard<=0, rready<=0, ->IDLE.
//     flush in DATA (incl. same cycle as accept) -> beat treated as discard.
//   HOLD: instr_valid=1 until instr_ack or flush -> instr_valid<=0, instr_err<=0, ->IDLE.
//     instr unchanged while held.
//   Latency (zero-wait slave): fetch_req@N, arvalid@N+1, arready@N+1, rvalid@N+2, instr_valid@N+3.
//   Exactly one outstanding read; no new AR before the R beat completes.
//   Reset mid-transaction: immediate return to reset values; outstanding beat is not awaited.
// TESTING
//   1 Zero-wait: pc=0x0000_0040, fetch_req@N, slave returns 0x0010_0093 OKAY -> araddr=0x40 @N+1,
//     instr=0x0010_0093, instr_valid=1 @N+3, fetch_stall 1->0 @N+3.
//   2 Backpressure: arready low 3 cycles -> arvalid stays 1, araddr stable 0x40; rvalid delayed 4 -> valid only after.
//   3 Flush in DATA: flush while awaiting rvalid, rdata=0xDEAD_BEEF -> instr_valid never 1; IDLE; next fetch 0x80 ok.
//   4 Error: rresp=2'b10 -> instr=0x0000_0013, instr_err=1, cleared on instr_ack.
//   5 Foreign RID=3: beat ignored, rready stays 1; following RID=0 beat captured.
//   6 Async reset in ADDR: rst=0 between edges -> arvalid=0, instr_valid=0 immediately; pc=0x6 -> araddr=0x4.

Source files
------------

// File: rtl/if_axi_fetch.sv
// IF-stage instruction fetch master: one single-beat AXI4 read per PC, with the
// returned word held for the IF/ID register and in-flight responses dropped on flush.
module if_axi_fetch #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned FETCH_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    input  logic              fetch_req,
    input  logic              flush,
    input  logic              instr_ack,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              instr_err,
    output logic              fetch_stall,
    output logic [PC_W-1:0]   araddr,
    output logic [ID_W-1:0]   arid,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [ID_W-1:0]   rid,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013);
    localparam logic [ID_W-1:0]   ID_FETCH = ID_W'(FETCH_ID);
    localparam logic [PC_W-1:0]   WORD_MSK = ~PC_W'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state;
    logic   discard;
    logic   beat_ok;

    // Fixed single-beat, 32-bit, INCR read attributes
    assign arid    = ID_FETCH;
    assign arlen   = 4'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign fetch_stall = ~instr_valid;

    // Only the final beat carrying our own ID completes the fetch
    assign beat_ok = rvalid & rlast & (rid == ID_FETCH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            araddr      <= '0;
            instr       <= NOP;
            instr_valid <= 1'b0;
            instr_err   <= 1'b0;
            discard     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        araddr  <= pc & WORD_MSK;
                        arvalid <= 1'b1;
                        discard <= 1'b0;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (beat_ok) begin
                        rready <= 1'b0;
                        if (discard || flush) begin
                            discard <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            instr       <= (rresp == 2'b00) ? rdata : NOP;
                            instr_err   <= (rresp != 2'b00);
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ack || flush) begin
                        instr_valid <= 1'b0;
                        instr_err   <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
